// File: rtl/soc_defs_pkg.sv
// Shared SoC definitions: fetch NOP encoding, ROM depth default, program-load state encoding.
package soc_defs;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam int          ROM_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;
endpackage

// File: rtl/rom_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Zero latency: word_vld/word_dat are presented on the cycle of the fourth byte.
// No backpressure of its own; the caller qualifies byte_vld.
module rom_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_vld,
    output logic [31:0] word_dat
);
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt <= 2'd0;
            asm_q    <= 24'd0;
        end else if (clr) begin
            byte_cnt <= 2'd0;
            asm_q    <= 24'd0;
        end else if (byte_vld) begin
            case (byte_cnt)
                2'd0:    asm_q[7:0]   <= byte_dat;
                2'd1:    asm_q[15:8]  <= byte_dat;
                2'd2:    asm_q[23:16] <= byte_dat;
                default: asm_q        <= asm_q;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // The fourth byte bypasses the buffer so the word is written on its own edge.
    assign word_vld = byte_vld && (byte_cnt == 2'd3);
    assign word_dat = {byte_dat, asm_q};
endmodule

// File: rtl/inst_rom.sv
// Instruction memory with combinational fetch port and byte-stream program loader.
// Fetch latency 0 (combinational); load writes a word on the edge of its fourth byte.
// Loader accepts one byte per cycle while in LOAD; core held in reset during a load.
module inst_rom
    import soc_defs::*;
#(
    parameter int          ADDR_W   = ROM_ADDR_W,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_o,
    input  logic        load_start_i,
    input  logic [15:0] load_len_i,
    input  logic [7:0]  load_byte_i,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic        load_abort_i,
    output logic        load_busy_o,
    output logic        load_done_o,
    output logic        load_err_o,
    output logic        core_rst_o
);
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    load_state_t       state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_idx;
    logic [31:0]       mem [2**ADDR_W];

    logic              byte_acc;
    logic              word_vld;
    logic [31:0]       word_dat;
    logic              len_ok;
    logic              last_word;
    logic [ADDR_W-1:0] fetch_idx;

    // Abort wins over a same-cycle byte, so the byte is never accepted.
    assign byte_acc  = (state == ST_LOAD) && load_valid_i && load_ready_o && !load_abort_i;
    assign len_ok    = (load_len_i != 16'd0) && (32'(load_len_i) <= (32'd1 << ADDR_W));
    assign last_word = word_vld && (word_idx == len_q - ONE);

    rom_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state != ST_LOAD) || load_abort_i),
        .byte_vld (byte_acc),
        .byte_dat (load_byte_i),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            word_idx     <= '0;
            load_ready_o <= 1'b0;
            load_busy_o  <= 1'b0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
            core_rst_o   <= 1'b0;
        end else begin
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    core_rst_o <= 1'b1;
                    if (load_start_i) begin
                        if (len_ok) begin
                            state        <= ST_LOAD;
                            len_q        <= load_len_i[ADDR_W:0];
                            word_idx     <= '0;
                            load_ready_o <= 1'b1;
                            load_busy_o  <= 1'b1;
                            core_rst_o   <= 1'b0;
                        end else begin
                            load_err_o <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_abort_i) begin
                        state        <= ST_IDLE;
                        load_ready_o <= 1'b0;
                        load_busy_o  <= 1'b0;
                        load_err_o   <= 1'b1;
                        core_rst_o   <= 1'b1;
                    end else if (word_vld) begin
                        word_idx <= word_idx + ONE;
                        if (last_word) begin
                            state        <= ST_DONE;
                            load_ready_o <= 1'b0;
                            load_busy_o  <= 1'b0;
                            load_done_o  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    core_rst_o <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && word_vld)
            mem[word_idx[ADDR_W-1:0]] <= word_dat;
    end

    assign fetch_idx = inst_addr_i[ADDR_W+1:2];

    always_comb begin
        inst_o = NOP_INST;
        if ((inst_addr_i[1:0] == 2'b00) && (inst_addr_i[31:ADDR_W+2] == '0) && (state == ST_IDLE))
            inst_o = mem[fetch_idx];
    end
endmodule

// File: doc/inst_rom.md
Name: inst_rom

Overview:
- Instruction-memory responder on the far end of the core's fetch interface: it answers the core's word fetch address with the instruction word.
- It also has a byte-stream program-load port with a valid/ready handshake. Bytes are packed little-endian into words and written at an auto-incrementing address.
- While a load is in progress it holds the core in reset, then releases it.
- It sits beside the core top in the SoC shell, between the external loader/UART and the core's instruction port.

Parameters:
- ADDR_W, 12, word-address width; memory depth is 2**ADDR_W words.
- NOP_INST, 32'h0000_0013, word returned for invalid or blocked fetches (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- inst_addr_i  in  32  byte fetch address from the core PC
- inst_o  out  32  instruction word to the core fetch stage (combinational read)
- load_start_i  in  1  starts a program load; sampled in IDLE only
- load_len_i  in  16  number of 32-bit words to load; sampled with load_start_i
- load_byte_i  in  8  program byte; lowest address first, little-endian within a word
- load_valid_i  in  1  load_byte_i is valid
- load_ready_o  out  1  block accepts a byte this cycle
- load_abort_i  in  1  abandons the current load
- load_busy_o  out  1  state is LOAD
- load_done_o  out  1  one-cycle pulse when the last word has been written
- load_err_o  out  1  one-cycle pulse on a bad length or an abort
- core_rst_o  out  1  active-low reset to the core; 0 while a load is in progress

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; byte counter, word index and assembly buffer cleared.
  - load_ready_o=0, load_busy_o=0, load_done_o=0, load_err_o=0, core_rst_o=0.
  - Memory contents are not cleared.
  - First cycle after reset is released: core_rst_o=1.
- Fetch read is combinational, zero latency (the core's fetch stage registers it):
  - word index = inst_addr_i[ADDR_W+1:2].
  - inst_o = NOP_INST if inst_addr_i[1:0]!=0, or inst_addr_i[31:ADDR_W+2]!=0, or state!=IDLE.
  - Otherwise inst_o = mem[index].
- State machine IDLE, LOAD, DONE:
  - IDLE, load_start_i=1, load_len_i in 1..2**ADDR_W: latch length, index=0, byte counter=0, go to LOAD.
  - IDLE, load_start_i=1, load_len_i=0 or >2**ADDR_W: pulse load_err_o next cycle, stay IDLE.
  - LOAD: load_ready_o=1, load_busy_o=1, core_rst_o=0.
    - A byte is accepted on each edge with load_valid_i & load_ready_o.
    - Byte k (k=0..3) goes to buffer bits [8k+7:8k].
    - On byte 3, mem[index] is written with {load_byte_i, buf[23:0]} on that same edge; index increments and the byte counter wraps to 0.
    - When the accepted byte completes word len-1: go to DONE.
  - DONE (exactly one cycle): load_done_o=1, load_ready_o=0, core_rst_o=0, then IDLE. core_rst_o=1 from the first IDLE cycle.
- Abort: load_abort_i=1 in LOAD takes priority over a same-cycle byte.
  - That byte is not accepted.
  - Partial-word bytes are discarded; already-written words remain.
  - Next state is IDLE with a one-cycle load_err_o; core_rst_o returns to 1 in IDLE.
- Ignored inputs:
  - load_abort_i outside LOAD.
  - load_start_i in LOAD or DONE.
  - load_valid_i outside LOAD (no side effect).
- Reset mid-load: LOAD is abandoned immediately; memory keeps the words written so far; no done or err pulse.
- Counters are ADDR_W+1 bits so a full-depth load (len=2**ADDR_W) terminates correctly without wrap.

Decomposition:
- Shared package (soc_defs): INST_NOP constant, ROM ADDR_W default, and the load state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- One natural sub-module: rom_byte_packer, holding the 2-bit byte counter, the 24-bit assembly buffer and the word-valid strobe. The FSM, word index and memory array stay in inst_rom.

Test Plan:
- Reset then fetch before any load, inst_addr_i=0x4, mem preloaded 0x00500093 -> inst_o=0x00500093; inst_addr_i=0x6 -> 0x00000013.
- start len=2, bytes 93,00,50,00,13,01,A0,00 with valid held high -> ready high 8 cycles; done pulses once; core_rst_o low throughout, then high. Fetch 0x0 -> 0x00500093; 0x4 -> 0x00A00113.
- Same load with valid toggling 1/0 each cycle -> identical memory result; done pulses 1 cycle after the 8th accepted byte.
- start len=0 -> load_err_o=1 for one cycle; state stays IDLE; core_rst_o stays 1. len=4097 with ADDR_W=12 -> same.
- start len=3, send 6 bytes, assert abort with the 7th byte valid -> err pulse; word 0 written; word 1 unchanged from before the load; core_rst_o back to 1.
- Fetch during LOAD at a valid address -> 0x00000013. Fetch at 0x0001_0000 in IDLE with ADDR_W=12 -> 0x00000013. rst low mid-load then high -> IDLE, partial words kept.
